// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache on the MEM-stage port.
// Hits finish in zero stall cycles. On a miss the line is evicted if it is
// dirty, then refilled over a line-wide req/ack memory handshake.
module dcache_responder #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  // line storage: valid/dirty are reset, tag/data are not
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag_arr [LINES];
  logic [127:0]       r_data    [LINES];

  logic [1:0]         r_state;
  logic [TAG_W-1:0]   r_mtag;     // latched miss tag
  logic [INDEX_W-1:0] r_midx;     // latched miss index
  logic               r_req;
  logic               r_we;
  logic [31:0]        r_maddr;
  logic [127:0]       r_mwdata;

  logic               w_req;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic [1:0]         w_word;
  logic [127:0]       w_line;
  logic [31:0]        w_word_data;
  logic               w_idle;
  logic               w_hit;
  logic               w_miss;
  logic               w_wr_hit;
  logic               w_victim_dirty;
  logic               w_fill;
  logic               w_unused;

  assign w_req  = cpu_read_i | cpu_write_i;
  assign w_tag  = cpu_addr_i[31:32-TAG_W];
  assign w_idx  = cpu_addr_i[3+INDEX_W:4];
  assign w_word = cpu_addr_i[3:2];
  assign w_unused = ^cpu_addr_i[1:0];

  assign w_line         = r_data[w_idx];
  assign w_idle         = (r_state == S_IDLE);
  assign w_hit          = w_req & r_valid[w_idx] & (r_tag_arr[w_idx] == w_tag);
  assign w_miss         = w_idle & w_req & ~w_hit;
  assign w_wr_hit       = w_idle & w_hit & cpu_write_i;
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
  // refill lands only on an ack for a request actually on the bus
  assign w_fill         = (r_state == S_ALLOC) & r_req & mem_ack_i & ~rst_i;

  // select the addressed word of the indexed line
  always_comb begin
    w_word_data = w_line[31:0];
    case (w_word)
      2'd0: w_word_data = w_line[31:0];
      2'd1: w_word_data = w_line[63:32];
      2'd2: w_word_data = w_line[95:64];
      2'd3: w_word_data = w_line[127:96];
      default: w_word_data = w_line[31:0];
    endcase
  end

  // a store with read also asserted is a store, so no load data for it
  assign cpu_rdata_o = (w_idle & w_hit & ~cpu_write_i) ? w_word_data : 32'd0;
  assign cpu_stall_o = ~w_idle | w_miss;

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_maddr;
  assign mem_wdata_o = r_mwdata;

  // controller: state, valid/dirty bits and registered memory-bus outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_dirty  <= '0;
      r_mtag   <= '0;
      r_midx   <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_maddr  <= 32'd0;
      r_mwdata <= 128'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            r_mtag <= w_tag;
            r_midx <= w_idx;
            r_req  <= 1'b1;
            if (w_victim_dirty) begin
              r_state  <= S_WB;
              r_we     <= 1'b1;
              r_maddr  <= {r_tag_arr[w_idx], w_idx, 4'b0000};
              r_mwdata <= w_line;
            end else begin
              r_state  <= S_ALLOC;
              r_we     <= 1'b0;
              r_maddr  <= {w_tag, w_idx, 4'b0000};
              r_mwdata <= 128'd0;
            end
          end
        end
        S_WB: begin
          // drop req for one cycle so the refill is a distinct transaction
          if (mem_ack_i) begin
            r_state  <= S_ALLOC;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_maddr  <= 32'd0;
            r_mwdata <= 128'd0;
          end
        end
        S_ALLOC: begin
          if (!r_req) begin
            r_req   <= 1'b1;
            r_maddr <= {r_mtag, r_midx, 4'b0000};
          end else if (mem_ack_i) begin
            r_valid[r_midx] <= 1'b1;
            r_dirty[r_midx] <= 1'b0;
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_maddr <= 32'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // data/tag arrays: store-hit word merge and line refill
  always_ff @(posedge clk_i) begin
    if (w_wr_hit && !rst_i) begin
      case (w_word)
        2'd0: r_data[w_idx][31:0]   <= cpu_wdata_i;
        2'd1: r_data[w_idx][63:32]  <= cpu_wdata_i;
        2'd2: r_data[w_idx][95:64]  <= cpu_wdata_i;
        2'd3: r_data[w_idx][127:96] <= cpu_wdata_i;
        default: r_data[w_idx][31:0] <= cpu_wdata_i;
      endcase
    end else if (w_fill) begin
      r_data[r_midx]    <= mem_rdata_i;
      r_tag_arr[r_midx] <= r_mtag;
    end
  end

endmodule
